// File: rtl/aes_uart_pkg.sv
// Shared constants, packer state encoding and baud helper for the UART-to-AES byte path.
package aes_uart_pkg;

    localparam int BYTE_W          = 8;
    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_BLOCK_W     = BYTE_W * AES_BLOCK_BYTES;

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } packer_state_t;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_block_packer_if.sv
// Byte-stream input and block valid/ready output of the packer; master is the packer side.
interface uart_block_packer_if
    import aes_uart_pkg::*;
#(
    parameter int BLOCK_W = AES_BLOCK_W
);
    logic               i_rx_done;
    logic [BYTE_W-1:0]  i_rx_data;
    logic [BLOCK_W-1:0] o_block;
    logic               o_block_valid;
    logic               i_block_ready;

    modport master (
        input  i_rx_done,
        input  i_rx_data,
        input  i_block_ready,
        output o_block,
        output o_block_valid
    );

    modport slave (
        output i_rx_done,
        output i_rx_data,
        output i_block_ready,
        input  o_block,
        input  o_block_valid
    );
endinterface

// File: rtl/uart_gap_timer.sv
// Idle-gap counter: counts enabled cycles, pulses expired on the terminal count and wraps.
module uart_gap_timer #(
    parameter int LIMIT = 1
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(LIMIT);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= (cnt_reg == TERMINAL) ? '0 : cnt_reg + CW'(1);
        end
    end

    assign expired = enable && (cnt_reg == TERMINAL);

endmodule

// File: rtl/uart_block_packer.sv
// Packs received UART bytes into AES blocks behind a one-deep output register.
// Define UART_BLOCK_PACKER_TIMEOUT_EN to discard partial blocks after an inter-byte idle gap.
module uart_block_packer
    import aes_uart_pkg::*;
#(
    parameter int CLOCK_FREQ    = 50_000_000,
    parameter int BAUD_RATE     = 9600,
    parameter int BLOCK_BYTES   = AES_BLOCK_BYTES,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_clear,
    uart_block_packer_if.master              bus,
    output logic [$clog2(BLOCK_BYTES+1)-1:0] o_byte_count,
    output logic                             o_overflow,
    output logic                             o_timeout
);
    localparam int BLOCK_W = BYTE_W * BLOCK_BYTES;
    localparam int CNT_W   = $clog2(BLOCK_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_BYTES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLOCK_BYTES);

    packer_state_t      state_reg, state_next;
    logic [BLOCK_W-1:0] asm_reg, asm_next, asm_shift;
    logic [BLOCK_W-1:0] block_reg, block_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               valid_reg, valid_next;
    logic               overflow_reg, overflow_next;
    logic               timeout_reg, timeout_next;
    logic               slot_free;
    logic               gap_expired;

    // Newest byte enters at the bottom so the first byte ends up in the top lane.
    for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_shift
        if (gi == 0) begin : g_in
            assign asm_shift[BYTE_W-1:0] = bus.i_rx_data;
        end else begin : g_mv
            assign asm_shift[gi*BYTE_W +: BYTE_W] = asm_reg[(gi-1)*BYTE_W +: BYTE_W];
        end
    end

    assign slot_free = !valid_reg || bus.i_block_ready;

`ifdef UART_BLOCK_PACKER_TIMEOUT_EN
    localparam int GAP_LIMIT = TIMEOUT_BYTES * 10 * clks_per_bit(CLOCK_FREQ, BAUD_RATE) - 1;

    logic gap_enable;
    logic gap_clear;

    assign gap_enable = (state_reg == S_FILL) && (count_reg != '0) && (count_reg != FULL_CNT);
    assign gap_clear  = (state_reg == S_FILL) && (i_clear || bus.i_rx_done);

    uart_gap_timer #(
        .LIMIT (GAP_LIMIT)
    ) u_gap_timer (
        .clk     (i_clk),
        .srst    (i_rst),
        .clear   (gap_clear),
        .enable  (gap_enable),
        .expired (gap_expired)
    );
`else
    assign gap_expired = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= S_FILL;
            asm_reg      <= '0;
            count_reg    <= '0;
            block_reg    <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            asm_reg      <= asm_next;
            count_reg    <= count_next;
            block_reg    <= block_next;
            valid_reg    <= valid_next;
            overflow_reg <= overflow_next;
            timeout_reg  <= timeout_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        asm_next      = asm_reg;
        count_next    = count_reg;
        block_next    = block_reg;
        valid_next    = valid_reg && !bus.i_block_ready;
        overflow_next = 1'b0;
        timeout_next  = 1'b0;

        case (state_reg)
            S_FILL: begin
                if (i_clear) begin
                    count_next = '0;
                end else if (bus.i_rx_done) begin
                    asm_next = asm_shift;
                    if (count_reg == LAST_IDX) begin
                        if (slot_free) begin
                            block_next = asm_shift;
                            valid_next = 1'b1;
                            count_next = '0;
                        end else begin
                            state_next = S_FULL;
                            count_next = FULL_CNT;
                        end
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end else if (gap_expired) begin
                    count_next   = '0;
                    timeout_next = 1'b1;
                end
            end
            S_FULL: begin
                // Completed block is parked in asm; any byte now has nowhere to go.
                overflow_next = bus.i_rx_done;
                if (slot_free) begin
                    block_next = asm_reg;
                    valid_next = 1'b1;
                    count_next = '0;
                    state_next = S_FILL;
                end
            end
            default: begin
                state_next = S_FILL;
            end
        endcase
    end

    assign bus.o_block       = block_reg;
    assign bus.o_block_valid = valid_reg;
    assign o_byte_count      = count_reg;
    assign o_overflow        = overflow_reg;
    assign o_timeout         = timeout_reg;

endmodule
